// File: rtl/alu_fetch_pkg.sv
// Shared types and constants for the CompALU instruction fetch stage.
package alu_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/alu_fetch_unit_fifo.sv
// Prefetch FIFO: power-of-two depth, simultaneous push/pop, synchronous clear.
module fetch_fifo
  import alu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && !clr && ((count_reg < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Empty FIFO presents zero so the consumer never sees uninitialised storage.
  assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/alu_fetch_unit.sv
// Instruction fetch stage feeding CompALU: PC walker, one outstanding imem read,
// prefetch FIFO, halt sentinel and flush. Optional macro: FETCH_PERF_CNT_EN (stall_cnt).
module alu_fetch_unit
  import alu_fetch_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [WORD_W-1:0] START_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] Instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] pc_reg, pc_next;
  logic              push, pop;
  logic [CNT_W-1:0]  fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= START_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    imem_req   = 1'b0;
    if (flush) begin
      pc_next = flush_pc & ~32'h3;
      // A response landing in the flush cycle retires the outstanding read.
      state_next = ((state_reg == S_WAIT || state_reg == S_DRAIN) && !imem_valid)
                   ? S_DRAIN : S_RUN;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_RUN;
            pc_next    = START_PC;
          end
        end
        S_RUN: begin
          if (fifo_count < CNT_W'(DEPTH)) begin
            imem_req   = 1'b1;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (imem_rdata == HALT_WORD) begin
              state_next = S_HALT;
            end else begin
              push       = 1'b1;
              pc_next    = pc_reg + PC_INC;
              state_next = S_RUN;
            end
          end
        end
        S_DRAIN: begin
          if (imem_valid) state_next = S_RUN;
        end
        S_HALT: state_next = S_HALT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign imem_addr   = imem_req ? pc_reg : '0;
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign halted      = (state_reg == S_HALT);
  assign busy        = (state_reg != S_IDLE);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .head      (Instruction),
    .count     (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Consumer is waiting on an active fetcher with nothing to hand over.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_cnt_reg <= '0;
    end else if (instr_ready && !instr_valid && stall_cnt_reg != 32'hFFFF_FFFF &&
                 (state_reg == S_RUN || state_reg == S_WAIT || state_reg == S_DRAIN)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_fetch_unit.sv
// Self-checking bench for alu_fetch_unit: transaction-level model plus directed scenarios.
module tb_alu_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] START_PC = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        halted;
  logic        busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  alu_fetch_unit #(
    .DEPTH     (DEPTH),
    .START_PC  (START_PC),
    .HALT_WORD (HALT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .busy        (busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // memory model state
  int unsigned lat = 1;
  logic [31:0] halt_addr = 32'h1;
  bit          mem_pend = 0;
  int          mem_due  = 0;
  logic [31:0] mem_a    = '0;

  // logs for directed checks
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] xfer_q[$];
  int          first_valid_cyc = -1;

  // reference model
  logic [31:0] m_q[$];
  logic [31:0] m_pc = START_PC;
  bit          m_out = 0, m_disc = 0, m_halted = 0, m_active = 0;
  logic [31:0] m_stall = '0;
  bit          rst_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Single compare process: checks outputs against the model, then advances it.
  always @(negedge clk) begin
    bit exp_valid, can_req, xfer;
    if (rst) begin
      if (rst_prev) begin
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_Instruction", Instruction, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
      end
      m_q.delete();
      m_pc = START_PC; m_out = 0; m_disc = 0; m_halted = 0; m_active = 0; m_stall = '0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      exp_valid = (m_q.size() != 0);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
      if (exp_valid) check("Instruction", Instruction, m_q[0]);
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("busy", {31'd0, busy}, {31'd0, m_active});
      // A running fetcher with no read in flight asks whenever the buffer has room.
      can_req = m_active && !m_halted && !m_out && !flush && (m_q.size() < DEPTH);
      check("imem_req", {31'd0, imem_req}, {31'd0, can_req});
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
      if (imem_req) begin
        check("imem_addr", imem_addr, m_pc);
        req_addr_q.push_back(imem_addr);
        req_cyc_q.push_back(cyc);
        mem_pend = 1; mem_due = cyc + int'(lat); mem_a = imem_addr;
      end
      xfer = instr_valid && instr_ready;
      if (xfer) begin
        xfer_q.push_back(Instruction);
        $display("xfer cyc=%0d instr=%h", cyc, Instruction);
      end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

`ifdef FETCH_PERF_CNT_EN
      if (flush) m_stall = '0;
      else if (instr_ready && m_q.size() == 0 && m_active && !m_halted && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 1;
`endif
      if (flush) begin
        m_q.delete();
        m_pc = flush_pc & ~32'h3;
        m_halted = 0;
        m_active = 1;
        m_out = m_out && !imem_valid;
        m_disc = m_out;
      end else begin
        if (xfer) void'(m_q.pop_front());
        if (start && !m_active) begin
          m_active = 1;
          m_pc = START_PC;
        end
        if (imem_valid && m_out) begin
          m_out = 0;
          if (!m_disc) begin
            if (imem_rdata == HALT) m_halted = 1;
            else begin
              m_q.push_back(imem_rdata);
              m_pc = m_pc + 32'd4;
            end
          end
        end
        if (imem_req) begin
          m_out = 1;
          m_disc = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    flush = 1'b0;
    if (mem_pend && cyc == mem_due) begin
      imem_valid = 1'b1;
      imem_rdata = (mem_a == halt_addr) ? HALT : mem_a;
      mem_pend = 0;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_pend = 0;
    halt_addr = 32'h1;
    lat = 1;
    req_addr_q.delete();
    req_cyc_q.delete();
    xfer_q.delete();
    first_valid_cyc = -1;
  endtask

  initial begin
    int c0;

    // Reset and start, 1-cycle memory
    do_reset();
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    c0 = cyc;
    tick(); tick(); tick();
`ifdef FETCH_PERF_CNT_EN
    check("stall_before_first", stall_cnt, 32'd2);
`endif
    repeat (8) tick();
    check("start_req_count_ge3", {31'd0, req_addr_q.size() >= 3}, 32'd1);
    check("start_addr0", req_addr_q[0], 32'h0);
    check("start_addr1", req_addr_q[1], 32'h4);
    check("start_addr2", req_addr_q[2], 32'h8);
    check("start_req_latency", req_cyc_q[0], c0 + 1);
    check("start_xfer_count_ge3", {31'd0, xfer_q.size() >= 3}, 32'd1);
    check("start_xfer0", xfer_q[0], 32'h0);
    check("start_xfer1", xfer_q[1], 32'h4);
    check("start_xfer2", xfer_q[2], 32'h8);
    check("first_valid_cyc", first_valid_cyc, c0 + 3);

    // Backpressure
    do_reset();
    instr_ready = 1'b0;
    tick();
    start = 1'b1;
    repeat (20) tick();
    check("bp_req_count", req_addr_q.size(), DEPTH);
    check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_Instruction", Instruction, 32'h0);
    instr_ready = 1'b1;
    repeat (12) tick();
    check("bp_xfer_count_ge4", {31'd0, xfer_q.size() >= 4}, 32'd1);
    check("bp_xfer1", xfer_q[1], 32'h4);
    check("bp_xfer3", xfer_q[3], 32'hC);

    // Halt at address 8
    do_reset();
    halt_addr = 32'h8;
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    repeat (15) tick();
    check("halt_xfer_count", xfer_q.size(), 2);
    check("halt_xfer0", xfer_q[0], 32'h0);
    check("halt_xfer1", xfer_q[1], 32'h4);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_req_count", req_addr_q.size(), 3);

    // Flush while a 3-cycle read is outstanding
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    c0 = cyc;
    tick(); tick();
    flush = 1'b1;
    flush_pc = 32'h100;
    repeat (12) tick();
    check("flush_req_count_ge2", {31'd0, req_addr_q.size() >= 2}, 32'd1);
    check("flush_new_addr", req_addr_q[1], 32'h100);
    check("flush_req_cyc", req_cyc_q[1], c0 + 5);
    check("flush_first_xfer", xfer_q[0], 32'h100);
    check("flush_first_valid", first_valid_cyc, c0 + 9);

    // Wrap-around
    do_reset();
    instr_ready = 1'b1;
    tick();
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    repeat (6) tick();
    check("wrap_addr0", req_addr_q[0], 32'hFFFF_FFFC);
    check("wrap_addr1", req_addr_q[1], 32'h0000_0000);
    check("wrap_xfer0", xfer_q[0], 32'hFFFF_FFFC);

    // Randomised traffic against the model
    do_reset();
    halt_addr = 32'(4 * $urandom_range(4, 40));
    tick();
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      lat = $urandom_range(1, 3);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 2) begin
        flush = 1'b1;
        flush_pc = 32'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) < 3) start = 1'b1;
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
        halt_addr = 32'(4 * $urandom_range(4, 40));
        start = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_fetch_unit.md
# alu_fetch_unit

Instruction fetch stage placed directly upstream of the CompALU datapath. It walks a program counter through an external instruction memory and buffers returned words in a small prefetch FIFO. It presents them to CompALU's `Instruction` input through a valid/ready handshake, stops on a halt sentinel word, and supports redirect (flush) to a new PC.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2 to 16.
- `START_PC`, 32'h0000_0000: byte address of the first fetch after `start`.
- `HALT_WORD`, 32'hFFFF_FFFF: sentinel instruction that ends fetching.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins fetching from `START_PC`. Honoured only in IDLE.
- `flush`, in, 1: redirect request.
- `flush_pc`, in, 32: new fetch byte address, sampled when `flush`=1.
- `imem_req`, out, 1: one-cycle read request pulse.
- `imem_addr`, out, 32: byte address, valid when `imem_req`=1.
- `imem_valid`, in, 1: read data valid.
- `imem_rdata`, in, 32: instruction word.
- `Instruction`, out, 32: FIFO head, driving CompALU `Instruction`.
- `instr_valid`, out, 1: `Instruction` holds a valid word.
- `instr_ready`, in, 1: consumer accepts the word.
- `halted`, out, 1: sentinel seen, fetching stopped.
- `busy`, out, 1: state is not IDLE.

## Operation
- States:
  - IDLE (reset): `start` moves to RUN with pc=`START_PC`. `flush` moves to RUN with pc=`flush_pc`.
  - RUN: issues `imem_req` with `imem_addr`=pc when FIFO count < `DEPTH`, then moves to WAIT. This guarantees space for the returning word.
  - WAIT: exactly one request is outstanding. On `imem_valid`:
    - If the word is not `HALT_WORD`: push it, pc += 4, go to RUN.
    - If the word equals `HALT_WORD`: do not push it, go to HALT.
  - HALT: no requests are issued. The FIFO keeps draining normally. Only `flush` or `rst` leaves HALT.
  - DRAIN: entered on `flush` while in WAIT. Waits for the outstanding response, discards it, then goes to RUN.
- pc is 32 bits and wraps from 32'hFFFF_FFFC to 0. The low 2 bits of pc are always 0; the low 2 bits of `flush_pc` are forced to 0.
- Downstream handshake:
  - A transfer occurs when `instr_valid`&`instr_ready`.
  - While `instr_valid`=1 and `instr_ready`=0, `Instruction` is held stable.
- `flush` in any state:
  - FIFO is emptied; `instr_valid`=0 next cycle.
  - pc ← `flush_pc`.
  - `halted` clears.
  - A response arriving in the same cycle is discarded.
  - A downstream transfer in that cycle still counts as completed.
  - Next state: DRAIN if a request is outstanding (WAIT or DRAIN), otherwise RUN.
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.
- `start` outside IDLE is ignored. `start` and `flush` asserted together: `flush` wins.
- `imem_valid` in IDLE, RUN or HALT is a protocol error and is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `Instruction`=0, `instr_valid`=0, `halted`=0, `busy`=0, pc=`START_PC`, FIFO empty, state IDLE.
- Fetch path, with `start` sampled at cycle 0:
  - `imem_req` asserted at cycle 1.
  - With a 1-cycle memory, `imem_valid` arrives at cycle 2.
  - `instr_valid`=1 from cycle 3.
- Throughput: with a 1-cycle memory, one request every 2 cycles (RUN→WAIT→RUN).
- `halted` rises the cycle after the sentinel response is sampled.
- Flush to first request:
  - With nothing outstanding: next cycle.
  - With a request outstanding: the cycle after the discarded response.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds output `stall_cnt`, 32 bits.
  - Counts cycles with `instr_ready`=1, `instr_valid`=0 and state in RUN, WAIT or DRAIN.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by `rst` and `flush`.
- Not defined: no port and no counter logic.

## Structure
- Package `alu_fetch_pkg`:
  - FSM state enum (IDLE, RUN, WAIT, DRAIN, HALT).
  - Word width 32.
  - PC increment constant 4.
  - Default `HALT_WORD`.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO parameterised by `DEPTH`, with a count output.
  - Supports simultaneous push and pop.
  - Has a synchronous clear input, driven by `flush`.

## Test plan
- **Reset and start:** `rst`, then `start` pulse with 1-cycle memory returning word = address.
  - `imem_addr` sequence 0, 4, 8.
  - `Instruction` sequence 0, 4, 8 in order, first `instr_valid` at cycle 3.
- **Backpressure:** `instr_ready`=0 with `DEPTH`=4.
  - Exactly 4 requests are issued, then `imem_req` stays 0.
  - `Instruction` stays 0 (the first word) until `instr_ready`=1.
- **Halt:** memory returns `HALT_WORD` at address 8.
  - Words 0 and 4 are delivered; the sentinel is never presented.
  - `halted`=1 and no further requests.
- **Flush with request outstanding:** `flush`, `flush_pc`=32'h100 while in WAIT with a 3-cycle memory.
  - The old response is discarded.
  - The next `imem_addr` is 32'h100; `instr_valid` is 0 until the new word arrives.
- **Wrap-around:** `flush_pc`=32'hFFFF_FFFC, then run.
  - `imem_addr` sequence FFFF_FFFC, 0000_0000.
- **Perf counter** (`FETCH_PERF_CNT_EN`): `instr_ready`=1 with a 1-cycle memory from `start`.
  - `stall_cnt`=2 before the first transfer.
